// File: rtl/mc_pkg.sv
// Shared types for the multicycle ARM-subset control unit: FSM states, control word, decode helpers.
// Optional feature macro MC_LDRB_EN (byte loads) is consumed in mc_controller.sv.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_src;
      logic [1:0] imm_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [2:0] alu_control;
      logic       reg_byte;
   } ctrl_t;

   localparam ctrl_t FETCH_CTRL = '{pc_write: 1'b1, adr_src: 1'b0, mem_write: 1'b0,
                                   ir_write: 1'b1, reg_write: 1'b0, reg_src: 2'b00,
                                   imm_src: 2'b00, alu_src_a: 1'b1, alu_src_b: 2'b10,
                                   result_src: 2'b10, alu_control: ALU_ADD, reg_byte: 1'b0};

   typedef struct packed {
      logic [2:0] alu;
      logic       nowrite;
      logic       wr_nz;
      logic       wr_cv;
   } cmd_dec_t;

   // Unrecognised commands behave as a non-writing, non-flag-setting ADD.
   function automatic cmd_dec_t cmd_decode(input logic [3:0] cmd);
      cmd_dec_t d;
      case (cmd)
         CMD_ADD: d = '{alu: ALU_ADD, nowrite: 1'b0, wr_nz: 1'b1, wr_cv: 1'b1};
         CMD_SUB: d = '{alu: ALU_SUB, nowrite: 1'b0, wr_nz: 1'b1, wr_cv: 1'b1};
         CMD_AND: d = '{alu: ALU_AND, nowrite: 1'b0, wr_nz: 1'b1, wr_cv: 1'b0};
         CMD_ORR: d = '{alu: ALU_ORR, nowrite: 1'b0, wr_nz: 1'b1, wr_cv: 1'b0};
         CMD_CMP: d = '{alu: ALU_SUB, nowrite: 1'b1, wr_nz: 1'b1, wr_cv: 1'b1};
         default: d = '{alu: ALU_ADD, nowrite: 1'b1, wr_nz: 1'b0, wr_cv: 1'b0};
      endcase
      return d;
   endfunction

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, r;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = c;
         COND_CC: r = ~c;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = c & ~z;
         COND_LS: r = ~c | z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = z | (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_condlogic.sv
// NZCV flag register, condition evaluation and the per-instruction condex_q latch.
module mc_condlogic
   import mc_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'h0
) (
   input  logic       clk,
   input  logic       reset,
   input  state_t     state,
   input  logic [3:0] cond,
   input  logic       s_bit,
   input  logic [3:0] cmd,
   input  logic [3:0] alu_flags,
   output logic       condex,
   output logic       condex_q
);

   logic [3:0] flags_r;
   cmd_dec_t   dec_s;
   logic       nz_we_s;
   logic       cv_we_s;

   // Flag write-mask: only S-suffixed, condition-passed data-processing ops touch flags
   always_comb begin
      dec_s   = cmd_decode(cmd);
      nz_we_s = ((state == S_EXECR) || (state == S_EXECI)) & s_bit & condex_q & dec_s.wr_nz;
      cv_we_s = ((state == S_EXECR) || (state == S_EXECI)) & s_bit & condex_q & dec_s.wr_cv;
      condex  = cond_eval(cond, flags_r);
   end

   // Flag register and DECODE-time capture of the condition result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_r  <= RESET_FLAGS;
         condex_q <= 1'b0;
      end else begin
         if (nz_we_s) flags_r[3:2] <= alu_flags[3:2];
         if (cv_we_s) flags_r[1:0] <= alu_flags[1:0];
         if (state == S_DECODE) condex_q <= condex;
      end
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset datapath; outputs are registered per state.
// Optional macro MC_LDRB_EN enables RegByte for byte loads (LDRB behaves as LDR when undefined).
module mc_controller
   import mc_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ImmSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [2:0]  ALUControl,
   output logic        RegByte,
   output logic [3:0]  StateOut
);

   state_t state_r;
   state_t state_next_s;
   ctrl_t  ctrl_r;
   ctrl_t  ctrl_next_s;
   logic   condex_s;
   logic   condex_q_s;
   logic   cx_sel_s;

   mc_condlogic #(.RESET_FLAGS(RESET_FLAGS)) u_condlogic (
      .clk       (clk),
      .reset     (reset),
      .state     (state_r),
      .cond      (Instr[31:28]),
      .s_bit     (Instr[20]),
      .cmd       (Instr[24:21]),
      .alu_flags (ALUFlags),
      .condex    (condex_s),
      .condex_q  (condex_q_s)
   );

   // A write to R15 from either writeback state also loads the PC.
   function automatic ctrl_t state_ctrl(input state_t st, input logic [31:0] instr, input logic cx);
      ctrl_t    c;
      cmd_dec_t d;
      logic     wr;
      c  = '0;
      d  = cmd_decode(instr[24:21]);
      wr = 1'b0;
      case (st)
         S_FETCH:  c = FETCH_CTRL;
         S_DECODE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMADR: begin
            c.alu_src_b = 2'b01;
            c.imm_src   = 2'b01;
         end
         S_MEMRD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = cx;
            c.pc_write   = cx & (instr[15:12] == 4'd15);
`ifdef MC_LDRB_EN
            c.reg_byte   = instr[22];
`else
            c.reg_byte   = 1'b0;
`endif
         end
         S_MEMWR: begin
            c.adr_src   = 1'b1;
            c.reg_src   = 2'b10;
            c.mem_write = cx;
         end
         S_EXECR:  c.alu_control = d.alu;
         S_EXECI: begin
            c.alu_src_b   = 2'b01;
            c.alu_control = d.alu;
         end
         S_ALUWB: begin
            wr          = cx & ~d.nowrite;
            c.reg_write = wr;
            c.pc_write  = wr & (instr[15:12] == 4'd15);
         end
         S_BRANCH: begin
            c.reg_src    = 2'b01;
            c.alu_src_b  = 2'b01;
            c.imm_src    = 2'b10;
            c.result_src = 2'b10;
            c.pc_write   = cx;
         end
         default:  c = '0;
      endcase
      return c;
   endfunction

   // Next-state decode and the control word the next state will present
   always_comb begin
      state_next_s = S_FETCH;
      case (state_r)
         S_FETCH:  state_next_s = S_DECODE;
         S_DECODE: begin
            case (Instr[27:26])
               OP_MEM:  state_next_s = S_MEMADR;
               OP_DP:   state_next_s = Instr[25] ? S_EXECI : S_EXECR;
               OP_BR:   state_next_s = S_BRANCH;
               default: state_next_s = S_FETCH;
            endcase
         end
         S_MEMADR: state_next_s = Instr[20] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_next_s = S_MEMWB;
         S_EXECR:  state_next_s = S_ALUWB;
         S_EXECI:  state_next_s = S_ALUWB;
         default:  state_next_s = S_FETCH;
      endcase
      // Leaving DECODE, condex_q is only being captured, so use the live result.
      cx_sel_s    = (state_r == S_DECODE) ? condex_s : condex_q_s;
      ctrl_next_s = state_ctrl(state_next_s, Instr, cx_sel_s);
   end

   // State register with the control word registered alongside it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_FETCH;
         ctrl_r  <= FETCH_CTRL;
      end else begin
         state_r <= state_next_s;
         ctrl_r  <= ctrl_next_s;
      end
   end

   assign PCWrite    = ctrl_r.pc_write  & reset;
   assign IRWrite    = ctrl_r.ir_write  & reset;
   assign MemWrite   = ctrl_r.mem_write & reset;
   assign RegWrite   = ctrl_r.reg_write & reset;
   assign AdrSrc     = ctrl_r.adr_src;
   assign RegSrc     = ctrl_r.reg_src;
   assign ImmSrc     = ctrl_r.imm_src;
   assign ALUSrcA    = ctrl_r.alu_src_a;
   assign ALUSrcB    = ctrl_r.alu_src_b;
   assign ResultSrc  = ctrl_r.result_src;
   assign ALUControl = ctrl_r.alu_control;
   assign RegByte    = ctrl_r.reg_byte;
   assign StateOut   = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction-level model plus hand-computed spot checks.
module tb_mc_controller;
   import mc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, RegByte;
   logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
   logic [2:0]  ALUControl;
   logic [3:0]  StateOut;

   always #5 clk = ~clk;

   mc_controller #(.RESET_FLAGS(4'h0)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .RegByte(RegByte), .StateOut(StateOut)
   );

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] regsrc;
      logic [1:0] imm;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] res;
      logic [2:0] aluc;
      logic       rbyte;
      logic [3:0] st;
   } outv_t;

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [3:0] m_flags;
   logic       cap_pcw_br, cap_memw, cap_adr, cap_rbyte, cap_pcw_wb;
   logic [1:0] cap_regsrc;
   logic [2:0] cap_aluc;
   int         cap_regw_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Conditions come in complementary pairs; Cond[0] inverts the base test.
   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      if (c == 4'hE) return 1'b1;
      return base ^ c[0];
   endfunction

   function automatic logic [2:0] m_alu(input logic [3:0] cmd);
      if (cmd == 4'b0010 || cmd == 4'b1010) return 3'b001;
      if (cmd == 4'b0000) return 3'b010;
      if (cmd == 4'b1100) return 3'b011;
      return 3'b000;
   endfunction

   function automatic logic m_writes(input logic [3:0] cmd);
      return (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
   endfunction

   function automatic outv_t model_out(input state_t st, input logic [31:0] ins, input logic cp);
      outv_t o;
      logic  wr;
      o    = '0;
      o.st = st;
      case (st)
         S_FETCH:  begin o.irw = 1'b1; o.srca = 1'b1; o.srcb = 2'b10; o.res = 2'b10; o.pcw = 1'b1; end
         S_DECODE: begin o.srca = 1'b1; o.srcb = 2'b10; end
         S_MEMADR: begin o.srcb = 2'b01; o.imm = 2'b01; end
         S_MEMRD:  o.adr = 1'b1;
         S_MEMWB:  begin
            o.res  = 2'b01;
            o.regw = cp;
            o.pcw  = cp && (ins[15:12] == 4'hF);
`ifdef MC_LDRB_EN
            o.rbyte = ins[22];
`endif
         end
         S_MEMWR:  begin o.adr = 1'b1; o.regsrc = 2'b10; o.memw = cp; end
         S_EXECR:  o.aluc = m_alu(ins[24:21]);
         S_EXECI:  begin o.srcb = 2'b01; o.aluc = m_alu(ins[24:21]); end
         S_ALUWB:  begin
            wr     = cp && m_writes(ins[24:21]);
            o.regw = wr;
            o.pcw  = wr && (ins[15:12] == 4'hF);
         end
         S_BRANCH: begin o.regsrc = 2'b01; o.srcb = 2'b01; o.imm = 2'b10; o.res = 2'b10; o.pcw = cp; end
         default:  o = '0;
      endcase
      return o;
   endfunction

   function automatic outv_t dut_out();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc, ALUSrcA,
              ALUSrcB, ResultSrc, ALUControl, RegByte, StateOut};
   endfunction

   // Walk one instruction through its state path; entered while the DUT sits in FETCH.
   task automatic run(input logic [31:0] ins, input logic [3:0] af, input int stop_after);
      state_t path[$];
      logic   cp;
      Instr    = ins;
      ALUFlags = af;
      cp       = m_cond(ins[31:28], m_flags);
      path     = {S_FETCH, S_DECODE};
      case (ins[27:26])
         2'b01: begin
            path.push_back(S_MEMADR);
            if (ins[20]) begin path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
            else path.push_back(S_MEMWR);
         end
         2'b00: begin path.push_back(ins[25] ? S_EXECI : S_EXECR); path.push_back(S_ALUWB); end
         2'b10: path.push_back(S_BRANCH);
         default: ;
      endcase
      cap_pcw_br = 1'bx; cap_memw = 1'bx; cap_adr = 1'bx; cap_rbyte = 1'bx;
      cap_pcw_wb = 1'bx; cap_regsrc = 2'bxx; cap_aluc = 3'bxxx; cap_regw_cnt = 0;
      for (int k = 0; k < path.size() && k < stop_after; k++) begin
         @(negedge clk);
         chk($sformatf("out_%s_%h", path[k].name(), ins), 32'(dut_out()),
             32'(model_out(path[k], ins, cp)));
         cap_regw_cnt += int'(RegWrite);
         case (path[k])
            S_BRANCH: cap_pcw_br = PCWrite;
            S_MEMWR:  begin cap_memw = MemWrite; cap_adr = AdrSrc; cap_regsrc = RegSrc; end
            S_MEMWB:  cap_rbyte = RegByte;
            S_ALUWB:  cap_pcw_wb = PCWrite;
            S_EXECR, S_EXECI: begin
               cap_aluc = ALUControl;
               if (cp && ins[20]) begin
                  if (m_alu(ins[24:21]) == 3'b001 || ins[24:21] == 4'b0100) m_flags = af;
                  else if (ins[24:21] == 4'b0000 || ins[24:21] == 4'b1100) m_flags[3:2] = af[3:2];
               end
            end
            default: ;
         endcase
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b0; Instr = 32'd0; ALUFlags = 4'd0; m_flags = 4'h0;
      #3;
      chk("rst_state", StateOut, 32'd0);
      chk("rst_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
      #4 reset = 1'b1;

      run(32'hE0821003, 4'b1111, 99);          // ADD R1,R2,R3
      chk("add_aluc", cap_aluc, 32'd0);
      chk("add_regw_cnt", cap_regw_cnt, 32'd1);
      run(32'h0A000002, 4'b0000, 99);          // BEQ: flags untouched by ADD
      chk("beq_after_add", cap_pcw_br, 32'd0);
      run(32'hE0500000, 4'b0110, 99);          // SUBS equal
      chk("subs_aluc", cap_aluc, 32'd1);
      run(32'h0A000002, 4'b0000, 99);
      chk("beq_taken", cap_pcw_br, 32'd1);
      run(32'hE0510000, 4'b1000, 99);          // SUBS not equal
      run(32'h0A000002, 4'b0000, 99);
      chk("beq_not_taken", cap_pcw_br, 32'd0);
      run(32'hE5D54001, 4'b0000, 99);          // LDRB
`ifdef MC_LDRB_EN
      chk("ldrb_regbyte", cap_rbyte, 32'd1);
`else
      chk("ldrb_regbyte", cap_rbyte, 32'd0);
`endif
      chk("ldrb_regw_cnt", cap_regw_cnt, 32'd1);
      run(32'hE5821000, 4'b0000, 99);          // STR
      chk("str_memw", cap_memw, 32'd1);
      chk("str_adr", cap_adr, 32'd1);
      chk("str_regsrc", cap_regsrc, 32'd2);
      run(32'h05821000, 4'b0000, 99);          // STREQ with Z=0
      chk("streq_memw", cap_memw, 32'd0);
      run(32'hE0921003, 4'b0011, 99);          // ADDS sets C,V
      run(32'hE3911000, 4'b1100, 99);          // ORRS imm: NZ from ALU, CV hold
      chk("orrs_aluc", cap_aluc, 32'd3);
      run(32'h6A000000, 4'b0000, 99);          // BVS: V held at 1
      chk("bvs_taken", cap_pcw_br, 32'd1);
      run(32'hE082F003, 4'b0000, 99);          // ADD PC,...
      chk("add_pc_pcw", cap_pcw_wb, 32'd1);
      run(32'h1082F003, 4'b0000, 99);          // ADDNE PC fails (Z=1)
      chk("addne_pcw", cap_pcw_wb, 32'd0);
      chk("addne_regw_cnt", cap_regw_cnt, 32'd0);
      run(32'hEC000000, 4'b0000, 99);          // Op=11 NOP
      run(32'hF0821003, 4'b0000, 99);          // Cond=1111 never executes
      chk("nv_regw_cnt", cap_regw_cnt, 32'd0);
      run(32'hE0321003, 4'b0000, 99);          // unknown cmd with S: no flags, no write
      chk("eor_regw_cnt", cap_regw_cnt, 32'd0);
      run(32'h0A000002, 4'b0000, 99);          // Z still 1
      chk("beq_after_eor", cap_pcw_br, 32'd1);

      run(32'hE5821000, 4'b0000, 3);           // STR, stop on entry to MEMWR
      #1;
      chk("memwr_before_rst", MemWrite, 32'd1);
      reset = 1'b0;
      m_flags = 4'h0;
      #1;
      chk("rst_mid_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
      chk("rst_mid_state", StateOut, 32'd0);
      reset = 1'b1;
      #1;
      chk("post_rst_fetch", {PCWrite, IRWrite}, 32'd3);
      run(32'h0A000002, 4'b0000, 99);          // flags back to reset value
      chk("beq_after_rst", cap_pcw_br, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
